// File: rtl/fft8_stage3_bfly.sv
// fft8_stage3_bfly: final radix-2 DIT stage of an 8-point FFT.
// A single butterfly engine is time-multiplexed over k=0..3. It consumes
// the eight stage-2 outputs and produces bins X0..X7 in natural order.
// The FFT3_SAT_EN macro selects saturating arithmetic on the twiddle
// results, the -br negation and the final a+/-t adds. When the macro is
// undefined, all of these wrap modulo 2^W.
module fft8_stage3_bfly #(
  parameter int W        = 32,
  parameter int TW_Q     = 181,
  parameter int TW_SHIFT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_re,
  input  logic [8*W-1:0] in_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*W-1:0] out_re,
  output logic [8*W-1:0] out_im
);

  // The wide working width holds any br+/-bi sum, or its negation, times
  // TW_Q without loss. Every intermediate value is exact until fit().
  localparam int PW = W + 12;
  localparam logic signed [PW-1:0] TWQ  = PW'(TW_Q);
  localparam logic signed [PW-1:0] MAXV = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nx;
  logic [1:0]           k;
  logic [7:0][W-1:0]    xr, xi;   // captured frame
  logic [7:0][W-1:0]    yr, yi;   // result bins, filled two lanes per cycle
  logic [W-1:0]         ar, ai, br, bi, tr, ti;
  logic [W-1:0]         lo_r, lo_i, hi_r, hi_i;
  logic signed [PW-1:0] s_re, s_im;

  // Sign-extend a W-bit lane into the exact working width.
  function automatic logic signed [PW-1:0] sx(input logic [W-1:0] x);
    sx = {{(PW-W){x[W-1]}}, x};
  endfunction

  // Narrow an exact value back to W bits (clamp or wrap, per build).
  function automatic logic [W-1:0] fit(input logic signed [PW-1:0] v);
`ifdef FFT3_SAT_EN
    if (v > MAXV)      fit = MAXV[W-1:0];
    else if (v < MINV) fit = MINV[W-1:0];
    else               fit = v[W-1:0];
`else
    fit = v[W-1:0];
`endif
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_re    = yr;
  assign out_im    = yi;

  // Next-state logic. A frame moves from accept to CALC for four cycles to DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = CALC;
      CALC:    if (k == 2'd3) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared butterfly. Select the operand pair for k, then rotate b by W8^k.
  always_comb begin
    ar   = xr[{1'b0, k}];
    ai   = xi[{1'b0, k}];
    br   = xr[{1'b1, k}];
    bi   = xi[{1'b1, k}];
    s_re = '0;
    s_im = '0;
    tr   = br;
    ti   = bi;
    case (k)
      2'd1: begin
        s_re = ((sx(br) + sx(bi)) * TWQ) >>> TW_SHIFT;
        s_im = ((sx(bi) - sx(br)) * TWQ) >>> TW_SHIFT;
        tr   = fit(s_re);
        ti   = fit(s_im);
      end
      2'd2: begin
        tr = bi;
        ti = fit(-sx(br));
      end
      2'd3: begin
        s_re = ((sx(bi) - sx(br)) * TWQ) >>> TW_SHIFT;
        s_im = ((-sx(br) - sx(bi)) * TWQ) >>> TW_SHIFT;
        tr   = fit(s_re);
        ti   = fit(s_im);
      end
      default: begin
        tr = br;
        ti = bi;
      end
    endcase
    lo_r = fit(sx(ar) + sx(tr));
    lo_i = fit(sx(ai) + sx(ti));
    hi_r = fit(sx(ar) - sx(tr));
    hi_i = fit(sx(ai) - sx(ti));
  end

  // State register. Reset discards any frame in flight at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath registers. Capture happens at accept, then lanes k and k+4 are written each CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k  <= '0;
      xr <= '0;
      xi <= '0;
      yr <= '0;
      yi <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr <= in_re;
          xi <= in_im;
          k  <= '0;
        end
        CALC: begin
          yr[{1'b0, k}] <= lo_r;
          yi[{1'b0, k}] <= lo_i;
          yr[{1'b1, k}] <= hi_r;
          yi[{1'b1, k}] <= hi_i;
          k             <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
